transport_ctrl: RTL and testbench

//  Multi-track transport controller for the body-drums system: latches user selections, sequences

---
 rtl/transport_pkg.sv | 19 +
 rtl/time_counter.sv | 43 ++++
 rtl/transport_ctrl.sv | 175 +++++++++++++++++
 tb/tb_transport_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/transport_pkg.sv
// rtl/transport_pkg.sv - state encoding and song-name remap shared by transport_ctrl
package transport_pkg;

   // Encodings 4..7 are never produced; the FSM falls back to STANDBY if one appears.
   typedef enum logic [2:0] {
      STANDBY  = 3'd0,
      STARTING = 3'd1,
      PLAY     = 3'd2,
      RECORD   = 3'd3
   } state_t;

   // Names at or above the bank split sit BANK_GAP slots higher in memory.
   function automatic int unsigned song_choice_map(input int unsigned name,
                                                   input int unsigned split,
                                                   input int unsigned gap);
      return (name < split) ? name : name + gap;
   endfunction

endpackage

// File: rtl/time_counter.sv
// rtl/time_counter.sv - ready-strobe prescaler and saturating running-time seconds counter
//  clk          in   system clock
//  reset        in   asynchronous, active-high
//  clear        in   zero prescaler and seconds
//  enable       in   count ready strobes while high
//  ready        in   one-cycle sample strobe
//  running_time out  elapsed enabled seconds, saturates at all-ones
module time_counter #(
   parameter int unsigned TICK_DIV = 48000,
   parameter int unsigned TIME_W   = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              enable,
   input  logic              ready,
   output logic [TIME_W-1:0] running_time
);

   localparam int unsigned      PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0] prescale;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         prescale     <= '0;
         running_time <= '0;
      end else if (clear) begin
         prescale     <= '0;
         running_time <= '0;
      end else if (enable && ready) begin
         if (prescale == PRE_LAST) begin
            prescale <= '0;
            if (running_time != '1)
               running_time <= running_time + TIME_W'(1);
         end else begin
            prescale <= prescale + PRE_W'(1);
         end
      end
   end

endmodule

// File: rtl/transport_ctrl.sv
// rtl/transport_ctrl.sv - multi-track transport controller: standby/start/play/record sequencing
//  clk, reset           clock; asynchronous active-high reset
//  ready                one-cycle sample strobe feeding the running-time prescaler
//  but_ent, pause_sw    debounced enter button (level) and pause switch
//  *_sel                selections, sampled only on an accepted enter press in STANDBY
//  start_ack, song_done memory handshake / end-of-song
//  record_mode, track_rec_en, song_name, song_choice, effect_values   latched session settings
//  start_song, pause_song, running_time, start_err, state_out         transport status
module transport_ctrl
   import transport_pkg::*;
#(
   parameter int unsigned NUM_TRACKS  = 4,
   parameter int unsigned SONG_W      = 4,
   parameter int unsigned NUM_SONGS   = 12,
   parameter int unsigned BANK_SPLIT  = 6,
   parameter int unsigned BANK_GAP    = 2,
   parameter int unsigned EFFECT_W    = 17,
   parameter int unsigned TICK_DIV    = 48000,
   parameter int unsigned TIME_W      = 12,
   parameter int unsigned ACK_TIMEOUT = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ready,
   input  logic                  but_ent,
   input  logic                  pause_sw,
   input  logic                  record_mode_sel,
   input  logic [NUM_TRACKS-1:0] track_arm_sel,
   input  logic [SONG_W-1:0]     song_name_sel,
   input  logic [EFFECT_W-1:0]   effect_values_sel,
   input  logic                  start_ack,
   input  logic                  song_done,
   output logic                  record_mode,
   output logic [NUM_TRACKS-1:0] track_rec_en,
   output logic [SONG_W-1:0]     song_name,
   output logic [SONG_W-1:0]     song_choice,
   output logic [EFFECT_W-1:0]   effect_values,
   output logic                  start_song,
   output logic                  pause_song,
   output logic [TIME_W-1:0]     running_time,
   output logic                  start_err,
   output logic [2:0]            state_out
);

   localparam int unsigned      ACK_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

   state_t                state;
   state_t                state_nx;
   logic                  ent_prev;
   logic                  ent_edge;
   logic                  pause_q;
   logic [NUM_TRACKS-1:0] arm_mask;
   logic [ACK_W-1:0]      ack_cnt;
   logic                  sel_valid;
   logic                  accept;
   logic                  reject;
   logic                  ack_expired;
   logic                  running;
   logic                  stop;
   logic                  run_en;

   assign sel_valid   = 32'(song_name_sel) < NUM_SONGS;
   assign accept      = (state == STANDBY) && ent_edge && sel_valid;
   assign reject      = (state == STANDBY) && ent_edge && !sel_valid;
   // An ack arriving on the last allowed cycle still wins over the timeout.
   assign ack_expired = (state == STARTING) && !start_ack && (ack_cnt == ACK_LAST);
   assign running     = (state == PLAY) || (state == RECORD);
   // song_done and an enter edge together produce one stop, never a stop plus restart.
   assign stop        = running && (song_done || ent_edge);
   assign run_en      = running && !pause_song;
   assign state_out   = state;

   // ent_prev resets high so a button held through reset is not seen as a press.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ent_prev <= 1'b1;
         ent_edge <= 1'b0;
         pause_q  <= 1'b0;
      end else begin
         ent_prev <= but_ent;
         ent_edge <= but_ent & ~ent_prev;
         pause_q  <= pause_sw;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= STANDBY;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         STANDBY:  if (accept) state_nx = STARTING;
         STARTING: begin
            if (start_ack)
               state_nx = record_mode ? RECORD : PLAY;
            else if (ack_expired)
               state_nx = STANDBY;
         end
         PLAY, RECORD: if (stop) state_nx = STANDBY;
         default:  state_nx = STANDBY;
      endcase
   end

   // The stop cycle itself already shows paused / no record enables.
   always_comb begin
      start_song   = 1'b0;
      pause_song   = 1'b1;
      track_rec_en = '0;
      case (state)
         STARTING: start_song = 1'b1;
         PLAY:     pause_song = pause_q | stop;
         RECORD: begin
            pause_song = pause_q | stop;
            if (!pause_q && !stop)
               track_rec_en = arm_mask;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         song_name     <= '0;
         song_choice   <= '0;
         effect_values <= '0;
         record_mode   <= 1'b0;
         arm_mask      <= '0;
      end else if (accept) begin
         song_name     <= song_name_sel;
         song_choice   <= SONG_W'(song_choice_map(32'(song_name_sel), BANK_SPLIT, BANK_GAP));
         effect_values <= effect_values_sel;
         // Record with nothing armed falls back to playback.
         record_mode   <= record_mode_sel & (|track_arm_sel);
         arm_mask      <= track_arm_sel;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         start_err <= 1'b0;
      else if (accept)
         start_err <= 1'b0;
      else if (reject || ack_expired)
         start_err <= 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         ack_cnt <= '0;
      else if (state != STARTING)
         ack_cnt <= '0;
      else
         ack_cnt <= ack_cnt + ACK_W'(1);
   end

   // Clearing on accept also leaves the prescaler at zero when STARTING is left,
   // since it cannot count while STARTING.
   time_counter #(
      .TICK_DIV (TICK_DIV),
      .TIME_W   (TIME_W)
   ) u_time_counter (
      .clk          (clk),
      .reset        (reset),
      .clear        (accept),
      .enable       (run_en),
      .ready        (ready),
      .running_time (running_time)
   );

endmodule

// File: tb/tb_transport_ctrl.sv
// tb/tb_transport_ctrl.sv - randomized self-checking bench for transport_ctrl
module tb_transport_ctrl;

   localparam int NT    = 4;
   localparam int SW    = 4;
   localparam int NS    = 12;
   localparam int SPLIT = 6;
   localparam int GAP   = 2;
   localparam int EW    = 17;
   localparam int TDIV  = 4;
   localparam int TW    = 12;
   localparam int ACKTO = 64;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          ready = 1'b0;
   logic          but_ent = 1'b0;
   logic          pause_sw = 1'b0;
   logic          record_mode_sel = 1'b0;
   logic [NT-1:0] track_arm_sel = '0;
   logic [SW-1:0] song_name_sel = '0;
   logic [EW-1:0] effect_values_sel = '0;
   logic          start_ack = 1'b0;
   logic          song_done = 1'b0;
   logic          record_mode;
   logic [NT-1:0] track_rec_en;
   logic [SW-1:0] song_name;
   logic [SW-1:0] song_choice;
   logic [EW-1:0] effect_values;
   logic          start_song;
   logic          pause_song;
   logic [TW-1:0] running_time;
   logic          start_err;
   logic [2:0]    state_out;

   transport_ctrl #(
      .NUM_TRACKS(NT), .SONG_W(SW), .NUM_SONGS(NS), .BANK_SPLIT(SPLIT), .BANK_GAP(GAP),
      .EFFECT_W(EW), .TICK_DIV(TDIV), .TIME_W(TW), .ACK_TIMEOUT(ACKTO)
   ) dut (
      .clk(clk), .reset(reset), .ready(ready), .but_ent(but_ent), .pause_sw(pause_sw),
      .record_mode_sel(record_mode_sel), .track_arm_sel(track_arm_sel),
      .song_name_sel(song_name_sel), .effect_values_sel(effect_values_sel),
      .start_ack(start_ack), .song_done(song_done), .record_mode(record_mode),
      .track_rec_en(track_rec_en), .song_name(song_name), .song_choice(song_choice),
      .effect_values(effect_values), .start_song(start_song), .pause_song(pause_song),
      .running_time(running_time), .start_err(start_err), .state_out(state_out)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: session settings, phase (0 standby,1 starting,2 play,3 record),
   // and the number of ready strobes that landed while running and unpaused.
   int            exp_state = 0;
   int            strobes = 0;
   logic [SW-1:0] exp_name = '0;
   logic [SW-1:0] exp_choice = '0;
   logic [EW-1:0] exp_eff = '0;
   logic          exp_mode = 1'b0;
   logic [NT-1:0] exp_arm = '0;
   logic          exp_err = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // pause_sw still holds the value sampled at the last rising edge when this runs.
   task automatic check_outputs(input string tag);
      logic          ep;
      logic [NT-1:0] er;
      int            et;
      ep = (exp_state >= 2) ? pause_sw : 1'b1;
      er = (exp_state == 3 && !ep) ? exp_arm : '0;
      et = strobes / TDIV;
      if (et > (1 << TW) - 1) et = (1 << TW) - 1;
      check({tag, " state"},        32'(state_out),     32'(exp_state));
      check({tag, " start_song"},   32'(start_song),    (exp_state == 1) ? 32'd1 : 32'd0);
      check({tag, " pause_song"},   32'(pause_song),    32'(ep));
      check({tag, " track_rec_en"}, 32'(track_rec_en),  32'(er));
      check({tag, " running_time"}, 32'(running_time),  32'(et));
      check({tag, " song_name"},    32'(song_name),     32'(exp_name));
      check({tag, " song_choice"},  32'(song_choice),   32'(exp_choice));
      check({tag, " effect"},       32'(effect_values), 32'(exp_eff));
      check({tag, " record_mode"},  32'(record_mode),   32'(exp_mode));
      check({tag, " start_err"},    32'(start_err),     32'(exp_err));
   endtask

   task automatic do_reset(input logic ent);
      reset = 1'b1; but_ent = ent; ready = 1'b0; pause_sw = 1'b0;
      start_ack = 1'b0; song_done = 1'b0; record_mode_sel = 1'b0;
      track_arm_sel = '0; song_name_sel = '0; effect_values_sel = '0;
      tick(); tick();
      exp_state = 0; strobes = 0; exp_name = '0; exp_choice = '0;
      exp_eff = '0; exp_mode = 1'b0; exp_arm = '0; exp_err = 1'b0;
      check_outputs("reset");
      reset = 1'b0;
   endtask

   task automatic start_session(input int name, input logic mode,
                                input logic [NT-1:0] arm, input logic [EW-1:0] eff);
      song_name_sel = SW'(name); record_mode_sel = mode;
      track_arm_sel = arm; effect_values_sel = eff;
      but_ent = 1'b1;
      tick(); tick();
      but_ent = 1'b0;
      if (name < NS) begin
         exp_name   = SW'(name);
         exp_choice = SW'((name < SPLIT) ? name : name + GAP);
         exp_eff    = eff;
         exp_mode   = mode && (arm != 0);
         exp_arm    = arm;
         exp_err    = 1'b0;
         strobes    = 0;
         exp_state  = 1;
      end else begin
         exp_err = 1'b1;
      end
      check_outputs("press");
      song_name_sel = SW'($urandom); record_mode_sel = 1'($urandom);
      track_arm_sel = NT'($urandom); effect_values_sel = EW'($urandom);
   endtask

   task automatic ack_after(input int d, output int hi);
      hi = start_song ? 1 : 0;
      for (int i = 1; i < d; i++) begin
         song_done = 1'($urandom_range(1));
         tick();
         check_outputs("starting");
         if (start_song) hi++;
      end
      song_done = 1'b0;
      start_ack = 1'b1;
      tick();
      start_ack = 1'b0;
      exp_state = exp_mode ? 3 : 2;
      check_outputs("acked");
   endtask

   task automatic play_cycles(input int n, input int pmode, input int rpct);
      logic r;
      for (int i = 0; i < n; i++) begin
         check_outputs("play");
         r = ($urandom_range(99) < rpct);
         if (exp_state >= 2 && !pause_sw && r) strobes++;
         ready = r;
         case (pmode)
            0:       pause_sw = 1'b0;
            1:       pause_sw = 1'b1;
            default: if ($urandom_range(3) == 0) pause_sw = ~pause_sw;
         endcase
         tick();
      end
      ready = 1'b0;
   endtask

   // kind 0: song_done, 1: enter press, 2: both in the same cycle
   task automatic stop_session(input int kind);
      ready = 1'b0;
      if (kind != 0) begin
         but_ent = 1'b1;
         tick();
      end
      if (kind != 1) song_done = 1'b1;
      #1;
      check("stop pause_song", 32'(pause_song), 32'd1);
      check("stop track_rec_en", 32'(track_rec_en), 32'd0);
      tick();
      song_done = 1'b0;
      but_ent = 1'b0;
      exp_state = 0;
      for (int i = 0; i < 6; i++) begin
         check_outputs("stopped");
         ready = 1'($urandom_range(1));
         tick();
      end
      ready = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int hi;
      int name;

      // Button held through reset must not count as a press.
      do_reset(1'b1);
      for (int i = 0; i < 6; i++) begin
         tick();
         check_outputs("held");
      end
      but_ent = 1'b0;
      tick(); tick();
      start_session(3, 1'b0, 4'b0000, EW'($urandom));
      for (int i = 0; i < 8; i++) begin
         tick();
         check_outputs("one_entry");
      end
      ack_after(1, hi);
      play_cycles(6, 2, 50);
      stop_session(0);

      // Playback of name 7, ack on the fifth start cycle.
      start_session(7, 1'b0, 4'b1111, EW'($urandom));
      ack_after(5, hi);
      check("start_song cycles", 32'(hi), 32'd5);
      check("choice of 7", 32'(song_choice), 32'd9);
      play_cycles(10, 2, 50);
      stop_session(0);

      // Record mask 0101 with pause toggling.
      start_session(5, 1'b1, 4'b0101, EW'($urandom));
      ack_after(2, hi);
      play_cycles(40, 2, 50);
      stop_session(1);

      // Running time: 9 unpaused strobes give 2 s; paused strobes do not count.
      pause_sw = 1'b0;
      start_session(2, 1'b1, NT'($urandom_range(1, 15)), EW'($urandom));
      ack_after(1, hi);
      play_cycles(9, 0, 100);
      check("time after 9", 32'(running_time), 32'd2);
      pause_sw = 1'b1;
      tick();
      play_cycles(12, 1, 100);
      check("time paused", 32'(running_time), 32'd2);
      pause_sw = 1'b0;
      tick();
      play_cycles(8, 0, 100);
      check("time after 17", 32'(running_time), 32'd4);
      stop_session(2);

      // Start timeout, then a valid press clears the error.
      start_session(1, 1'b0, 4'b0000, EW'($urandom));
      hi = 0;
      for (int i = 0; i < ACKTO + 10; i++) begin
         if (!start_song) break;
         hi++;
         tick();
      end
      check("timeout cycles", 32'(hi), 32'(ACKTO));
      exp_state = 0;
      exp_err = 1'b1;
      check_outputs("timeout");
      start_session(10, 1'b0, 4'b0000, EW'($urandom));
      ack_after(3, hi);
      play_cycles(8, 2, 50);
      stop_session(0);

      // Invalid name sets the error without leaving STANDBY.
      start_session(13, 1'b1, 4'b0011, EW'($urandom));
      tick();
      check_outputs("invalid");
      start_session(11, 1'b1, 4'b1000, EW'($urandom));
      ack_after(2, hi);
      play_cycles(10, 2, 50);
      stop_session(2);

      // Randomized sessions.
      for (int s = 0; s < 15; s++) begin
         name = $urandom_range(15);
         start_session(name, 1'($urandom), NT'($urandom), EW'($urandom));
         if (name >= NS) begin
            tick();
            check_outputs("rand invalid");
            continue;
         end
         ack_after($urandom_range(1, 8), hi);
         play_cycles($urandom_range(10, 40), 2, 50);
         stop_session($urandom_range(2));
      end

      // Running time saturates at all-ones.
      pause_sw = 1'b0;
      start_session(4, 1'b0, 4'b0000, EW'($urandom));
      ack_after(1, hi);
      for (int i = 0; i < 16400; i++) begin
         ready = 1'b1;
         strobes++;
         tick();
      end
      ready = 1'b0;
      check("time saturated", 32'(running_time), 32'd4095);
      check_outputs("saturated");
      stop_session(0);

      // Asynchronous reset while waiting for the ack drops start_song at once.
      start_session(6, 1'b0, 4'b0000, EW'($urandom));
      #2;
      reset = 1'b1;
      #1;
      check("async start_song", 32'(start_song), 32'd0);
      check("async state", 32'(state_out), 32'd0);
      check("async pause_song", 32'(pause_song), 32'd1);
      check("async song_name", 32'(song_name), 32'd0);
      tick();
      exp_state = 0; strobes = 0; exp_name = '0; exp_choice = '0;
      exp_eff = '0; exp_mode = 1'b0; exp_arm = '0; exp_err = 1'b0;
      check_outputs("async reset");
      reset = 1'b0;
      tick();
      check_outputs("after reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
